// File: rtl/dp_core.sv
// Multi-cycle register-file datapath: accept -> read -> execute -> writeback, one command per 4 cycles.
// Optional build macro DP_R0_ZERO_EN makes register 0 a constant zero.
module dp_core #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_op,
  input  logic [$clog2(NREGS)-1:0] cmd_rd,
  input  logic [$clog2(NREGS)-1:0] cmd_ra,
  input  logic [$clog2(NREGS)-1:0] cmd_rb,
  input  logic [WIDTH-1:0]         cmd_imm,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         res_data,
  output logic                     res_err,
  output logic [4:0]               flags,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  localparam int unsigned AW  = $clog2(NREGS);
  localparam int unsigned Msb = WIDTH - 1;

  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
  localparam logic [3:0] OpAnd   = 4'd2;
  localparam logic [3:0] OpOr    = 4'd3;
  localparam logic [3:0] OpXor   = 4'd4;
  localparam logic [3:0] OpNot   = 4'd5;
  localparam logic [3:0] OpLsh   = 4'd6;
  localparam logic [3:0] OpRsh   = 4'd7;
  localparam logic [3:0] OpMov   = 4'd8;
  localparam logic [3:0] OpCmp   = 4'd9;
  localparam logic [3:0] OpLoadi = 4'd10;

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  state_e            state_q;
  logic              ready_q;
  logic [3:0]        op_q;
  logic [AW-1:0]     rd_q, ra_q, rb_q;
  logic [WIDTH-1:0]  imm_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  alu_q;
  logic [4:0]        nflags_q;
  logic              err_q;
  logic              wr_q;
  logic [WIDTH-1:0]  regs_q [NREGS];
  logic              res_valid_q;
  logic [WIDTH-1:0]  res_data_q;
  logic              res_err_q;
  logic [4:0]        flags_q;

  // ALU on the operands latched in READ
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_flags;
  logic             alu_c, alu_l, alu_f, alu_upd, alu_wr, alu_err;

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = a_q - b_q;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_l   = 1'b0;
    alu_f   = 1'b0;
    alu_upd = 1'b1;
    alu_wr  = 1'b1;
    alu_err = 1'b0;
    case (op_q)
      OpAdd: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_f   = (a_q[Msb] == b_q[Msb]) && (alu_res[Msb] != a_q[Msb]);
      end
      OpSub, OpCmp: begin
        alu_res = diff;
        alu_c   = (a_q < b_q);
        alu_l   = (a_q < b_q);
        alu_f   = (a_q[Msb] != b_q[Msb]) && (diff[Msb] != a_q[Msb]);
        alu_wr  = (op_q == OpSub);
      end
      OpAnd: alu_res = a_q & b_q;
      OpOr:  alu_res = a_q | b_q;
      OpXor: alu_res = a_q ^ b_q;
      OpNot: alu_res = ~a_q;
      OpLsh: alu_res = {a_q[WIDTH-2:0], 1'b0};
      OpRsh: alu_res = {1'b0, a_q[WIDTH-1:1]};
      OpMov: begin
        alu_res = a_q;
        alu_upd = 1'b0;
      end
      OpLoadi: begin
        alu_res = imm_q;
        alu_upd = 1'b0;
      end
      default: begin
        alu_err = 1'b1;
        alu_wr  = 1'b0;
        alu_upd = 1'b0;
      end
    endcase
`ifdef DP_R0_ZERO_EN
    // R0 never gets written, so its reset value of zero is what every read sees
    if (rd_q == '0) alu_wr = 1'b0;
`endif
    alu_flags = alu_upd ? {alu_c, alu_l, alu_f, (alu_res == '0), alu_res[Msb]} : flags_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_q       <= '0;
      nflags_q    <= '0;
      err_q       <= 1'b0;
      wr_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      flags_q     <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ready_q && cmd_valid) begin
            op_q    <= cmd_op;
            rd_q    <= cmd_rd;
            ra_q    <= cmd_ra;
            rb_q    <= cmd_rb;
            imm_q   <= cmd_imm;
            ready_q <= 1'b0;
            state_q <= StRead;
          end else begin
            ready_q <= 1'b1;
          end
        end
        StRead: begin
          a_q     <= regs_q[ra_q];
          b_q     <= regs_q[rb_q];
          state_q <= StExec;
        end
        StExec: begin
          alu_q    <= alu_res;
          nflags_q <= alu_flags;
          err_q    <= alu_err;
          wr_q     <= alu_wr;
          state_q  <= StWb;
        end
        StWb: begin
          if (wr_q) regs_q[rd_q] <= alu_q;
          flags_q     <= nflags_q;
          res_data_q  <= alu_q;
          res_err_q   <= err_q;
          res_valid_q <= 1'b1;
          ready_q     <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign flags     = flags_q;
  assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: doc/dp_core.md
DP_CORE -- requirements
Module: dp_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16: datapath and register width, 4..32.
REQ-002 SHALL have parameter NREGS, default 16: register count, power of two, 2..32; AW = log2(NREGS).
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid is also 1.
REQ-007 SHALL have ports cmd_op, input, 4 bits; cmd_rd, cmd_ra, cmd_rb, input, AW bits each; cmd_imm, input, WIDTH bits.
REQ-008 SHALL have port res_valid, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have ports res_data, output, WIDTH bits: result; res_err, output, 1 bit: illegal opcode.
REQ-010 SHALL have port flags, output, 5 bits: {C,L,F,Z,N}.
REQ-011 SHALL have port dbg_addr, input, AW bits; and port dbg_data, output, WIDTH bits: combinational register read.

Function
REQ-012 SHALL use opcode map 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(ra), 6 LSH(ra<<1), 7 RSH(ra>>1, logical), 8 MOV(ra), 9 CMP, 10 LOADI(imm); 11-15 illegal.
REQ-013 SHALL implement FSM IDLE->READ->EXEC->WB->IDLE, one cycle per state; cmd_ready=1 only in IDLE with rst high.
REQ-014 SHALL capture op, rd, ra, rb and imm on the accepting edge (IDLE, cmd_valid=1); cmd_* SHALL be ignored in other states.
REQ-015 SHALL latch ra/rb operands in READ, register the ALU result and next flags in EXEC, and write back and pulse res_valid in WB; res_valid SHALL occur exactly 3 cycles after the accept edge.
REQ-016 SHALL make the earliest next accept the edge after WB, giving a throughput of 1 command per 4 cycles.
REQ-017 SHALL write rd in WB for all legal ops except CMP; res_data SHALL carry the ALU result and hold it until the next WB.
REQ-018 SHALL handle ADD as modulo 2^WIDTH: C=carry out, F=signed overflow.
REQ-019 SHALL handle SUB/CMP as ra-rb: C=1 when ra<rb unsigned (borrow), L=1 when ra<rb unsigned, F=signed overflow.
REQ-020 SHALL, for every legal op except MOV/LOADI, set Z=(result==0) and N=result MSB; C/L/F SHALL be cleared for ops other than ADD/SUB/CMP.
REQ-021 SHALL, for MOV/LOADI, leave flags unchanged.
REQ-022 SHALL, for an illegal op, skip the write, leave flags unchanged, set res_data=0 and res_err=1 with the res_valid pulse; otherwise res_err=0.
REQ-023 SHALL apply the write at WB before the next READ, so back-to-back dependent commands see the new value.
REQ-024 SHALL allow rd==ra==rb and read the old value.
REQ-025 SHALL drive dbg_data as the register value at dbg_addr, combinationally.

Reset
REQ-026 SHALL, while rst=0, force state=IDLE, all registers=0, flags=0, res_data=0, res_valid=0, res_err=0, cmd_ready=0.
REQ-027 SHALL abort any in-flight command on rst assertion mid-operation: no writeback and no res_valid.
REQ-028 SHALL make cmd_ready=1 on the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL, with DP_R0_ZERO_EN defined, make register 0 always read 0 on operands and dbg_data, and ignore writes to R0 (flags still update, res_data still shows the result).
REQ-030 SHALL, without DP_R0_ZERO_EN, treat R0 as an ordinary writable register.

Verification
REQ-031 LOADI R1=5, LOADI R2=3, ADD R3=R1+R2 -> res_data 8, dbg R3=8, flags Z=0 N=0 C=0, res_valid 3 cycles after each accept.
REQ-032 SUB R4=R2-R1 (3-5) -> res_data 0xFFFE, C=1 L=1 N=1 Z=0 F=0; CMP R1,R1 -> Z=1, R4 unchanged.
REQ-033 LOADI R5=0x7FFF, LOADI R6=1, ADD -> 0x8000, F=1 N=1; LOADI 0xFFFF + 1 -> 0x0000, C=1 Z=1.
REQ-034 op=12 -> res_err=1, res_data 0, no register or flag change; cmd_valid held high -> cmd_ready low for 3 cycles after each accept.
REQ-035 rst pulled low during EXEC of ADD R7 -> R7 stays 0, no res_valid, all outputs at reset values.
REQ-036 With DP_R0_ZERO_EN: LOADI R0=9 -> dbg R0=0, res_data 9; without it -> dbg R0=9.
